// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: RV32M funct encodings and sequencer state type shared by the muldiv files
package muldiv_sequencer_pkg;
    localparam logic [2:0] FUNCT3_MUL    = 3'd0;
    localparam logic [2:0] FUNCT3_MULH   = 3'd1;
    localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
    localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
    localparam logic [2:0] FUNCT3_DIV    = 3'd4;
    localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
    localparam logic [2:0] FUNCT3_REM    = 3'd6;
    localparam logic [2:0] FUNCT3_REMU   = 3'd7;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    typedef enum logic [2:0] {
        MDS_IDLE,
        MDS_MUL_WAIT,
        MDS_DIV_RUN,
        MDS_DIV_FIX,
        MDS_DONE
    } mds_state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage bundle between the pipeline (master) and the RV32M sequencer (slave)
interface muldiv_if #(parameter int XLEN = 32);
    logic            ex_muldiv;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic            kill;
    logic            stall;
    logic [XLEN-1:0] muldiv_result;
    logic            muldiv_done;
    modport master (
        output ex_muldiv, ex_funct3, ex_rs1_data, ex_rs2_data, kill,
        input  stall, muldiv_result, muldiv_done
    );
    modport slave (
        input  ex_muldiv, ex_funct3, ex_rs1_data, ex_rs2_data, kill,
        output stall, muldiv_result, muldiv_done
    );
endinterface

// File: rtl/muldiv_sequencer_div_core.sv
// muldiv_sequencer_div_core: unsigned restoring divider, one quotient bit per cycle
module muldiv_sequencer_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);
    localparam int CW = $clog2(XLEN);
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt;
    logic            busy;
    logic [XLEN:0]   sh, diff;
    assign sh   = {remainder, quotient[XLEN-1]};
    assign diff = sh - {1'b0, dvs_q};
    assign done = busy && cnt == CW'(XLEN-1);
    // Shift the next dividend bit into the partial remainder and subtract when it fits
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dvs_q     <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            quotient  <= dividend;
            remainder <= '0;
            dvs_q     <= divisor;
        end else if (busy) begin
            busy      <= !done;
            cnt       <= cnt + 1'b1;
            remainder <= diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], !diff[XLEN]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M multiply/divide sequencer for EX; MULDIV_DIV_CACHE_EN enables a last-division result cache
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    mds_state_t        state, state_d;
    logic [2:0]        f3, op_q;
    logic [XLEN-1:0]   rs1, rs2, dvd, dvs, core_q, core_r, fix_q, fix_r, div_res_q, mul_word, cache_res;
    logic [XLEN:0]     a_ext, b_ext;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] mul_pipe [MUL_LATENCY];
    logic [1:0]        mul_cnt;
    logic              sgn, div_zero, div_ovf, go, core_start, core_done, neg_q, rneg_q, cache_hit;
    assign f3         = bus.ex_funct3;
    assign rs1        = bus.ex_rs1_data;
    assign rs2        = bus.ex_rs2_data;
    assign sgn        = !f3[0];
    assign div_zero   = rs2 == '0;
    assign div_ovf    = sgn && rs1 == INT_MIN && rs2 == '1;
    assign go         = state == MDS_IDLE && bus.ex_muldiv && !bus.kill && !cache_hit;
    assign core_start = go && f3[2] && !div_zero && !div_ovf;
    assign dvd        = (sgn && rs1[XLEN-1]) ? -rs1 : rs1;
    assign dvs        = (sgn && rs2[XLEN-1]) ? -rs2 : rs2;
    assign a_ext      = {f3 != FUNCT3_MULHU && rs1[XLEN-1], rs1};
    assign b_ext      = {!f3[1] && rs2[XLEN-1], rs2};
    assign prod       = {{(XLEN-1){a_ext[XLEN]}}, a_ext} * {{(XLEN-1){b_ext[XLEN]}}, b_ext};
    assign mul_word   = op_q == FUNCT3_MUL ? mul_pipe[MUL_LATENCY-1][XLEN-1:0] : mul_pipe[MUL_LATENCY-1][2*XLEN-1:XLEN];
    assign fix_q      = neg_q ? -core_q : core_q;
    assign fix_r      = rneg_q ? -core_r : core_r;
    muldiv_sequencer_div_core #(.XLEN(XLEN)) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .abort    (bus.kill),
        .dividend (dvd),
        .divisor  (dvs),
        .quotient (core_q),
        .remainder(core_r),
        .done     (core_done)
    );
`ifdef MULDIV_DIV_CACHE_EN
    logic            c_valid, c_sgn;
    logic [XLEN-1:0] c_rs1, c_rs2, c_q, c_r;
    assign cache_hit = state == MDS_IDLE && bus.ex_muldiv && f3[2] && c_valid && c_rs1 == rs1 && c_rs2 == rs2 && c_sgn == sgn;
    assign cache_res = f3[1] ? c_r : c_q;
    // Remember operands and fixed results of the last normal division that completed
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_sgn   <= 1'b0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_q     <= '0;
            c_r     <= '0;
        end else if (state == MDS_DIV_FIX && !bus.kill) begin
            c_valid <= 1'b1;
            c_sgn   <= !op_q[0];
            c_rs1   <= rs1;
            c_rs2   <= rs2;
            c_q     <= fix_q;
            c_r     <= fix_r;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= MDS_IDLE;
        else     state <= state_d;
    end
    // Op latch, multiplier shift register, wait counter and divide result register
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            div_res_q <= '0;
            mul_cnt   <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) mul_pipe[i] <= '0;
        end else begin
            mul_pipe[0] <= state == MDS_IDLE ? prod : mul_pipe[0];
            for (int i = 1; i < MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
            mul_cnt <= state == MDS_MUL_WAIT ? mul_cnt + 1'b1 : '0;
            if (go) begin
                op_q      <= f3;
                neg_q     <= sgn && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                rneg_q    <= sgn && rs1[XLEN-1];
                div_res_q <= f3[1] ? (div_zero ? rs1 : '0) : (div_zero ? '1 : INT_MIN);
            end
            if (state == MDS_DIV_FIX) div_res_q <= op_q[1] ? fix_r : fix_q;
        end
    end
    // Next state plus stall/done/result towards the pipeline
    always_comb begin
        state_d = state;
        case (state)
            MDS_IDLE:     if (go) state_d = !f3[2] ? (MUL_LATENCY == 1 ? MDS_DONE : MDS_MUL_WAIT)
                                          : (div_zero || div_ovf) ? MDS_DONE : MDS_DIV_RUN;
            MDS_MUL_WAIT: if (mul_cnt == 2'(MUL_LATENCY-2)) state_d = MDS_DONE;
            MDS_DIV_RUN:  if (core_done) state_d = MDS_DIV_FIX;
            MDS_DIV_FIX:  state_d = MDS_DONE;
            default:      state_d = MDS_IDLE;
        endcase
        if (bus.kill) state_d = MDS_IDLE;
        bus.stall         = bus.ex_muldiv && state != MDS_DONE && !bus.kill && !cache_hit;
        bus.muldiv_done   = (state == MDS_DONE || cache_hit) && !bus.kill;
        bus.muldiv_result = cache_hit ? cache_res : state == MDS_DONE ? (op_q[2] ? div_res_q : mul_word) : '0;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed RV32M vectors with a queue scoreboard checking result and stall count
module tb_muldiv_sequencer;
    localparam int XLEN = 32;
`ifdef MULDIV_DIV_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    typedef struct {
        string       name;
        logic [31:0] res;
        int          stalls;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int n_checks = 0;
    int n_pass = 0;
    int stall_cnt = 0;
    bit tag_valid = 1'b0;
    bit tag_s = 1'b0;
    logic [31:0] tag_a = '0;
    logic [31:0] tag_b = '0;
    muldiv_if #(.XLEN(XLEN)) bus ();
    muldiv_sequencer #(.XLEN(XLEN), .MUL_LATENCY(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    // Monitor: counts stall cycles and checks each completion against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst || bus.kill) stall_cnt = 0;
        else if (bus.muldiv_done) begin
            if (q.size() == 0) check("unexpected_done", {31'b0, bus.muldiv_done}, 32'd0);
            else begin
                e = q.pop_front();
                check({e.name, "_result"}, bus.muldiv_result, e.res);
                check({e.name, "_stalls"}, stall_cnt, e.stalls);
            end
            stall_cnt = 0;
        end else if (bus.stall) stall_cnt++;
    end
    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int stalls);
        exp_t e;
        bit normal_div;
        int n;
        normal_div = f3[2] && b != 0 && !(!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (CACHE && normal_div && tag_valid && tag_a == a && tag_b == b && tag_s == !f3[0]) stalls = 0;
        e.name = name;
        e.res = res;
        e.stalls = stalls;
        q.push_back(e);
        bus.ex_funct3 = f3;
        bus.ex_rs1_data = a;
        bus.ex_rs2_data = b;
        bus.ex_muldiv = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.muldiv_done && n < 200);
        if (!bus.muldiv_done) check({name, "_timeout"}, {31'b0, bus.muldiv_done}, 32'd1);
        if (normal_div) begin
            tag_valid = 1'b1;
            tag_a = a;
            tag_b = b;
            tag_s = !f3[0];
        end
        @(posedge clk);
        #1;
        bus.ex_muldiv = 1'b0;
    endtask
    task automatic pulse_reset();
        rst = 1'b1;
        bus.ex_muldiv = 1'b0;
        tag_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_done", {31'b0, bus.muldiv_done}, 32'd0);
        check("rst_result", bus.muldiv_result, 32'd0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.ex_muldiv = 1'b0;
        bus.ex_funct3 = '0;
        bus.ex_rs1_data = '0;
        bus.ex_rs2_data = '0;
        bus.kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();
        issue("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        issue("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        issue("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        issue("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        issue("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        issue("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        issue("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
        issue("rem_negdiv", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        issue("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue("remu_zero", 3'd7, 32'd5, 32'd0, 32'd5, 1);
        issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        bus.ex_funct3 = 3'd4;
        bus.ex_rs1_data = 32'd1000;
        bus.ex_rs2_data = 32'd3;
        bus.ex_muldiv = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(negedge clk);
        check("kill_stall", {31'b0, bus.stall}, 32'd0);
        check("kill_done", {31'b0, bus.muldiv_done}, 32'd0);
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        bus.ex_muldiv = 1'b0;
        @(negedge clk);
        check("post_kill_stall", {31'b0, bus.stall}, 32'd0);
        check("post_kill_done", {31'b0, bus.muldiv_done}, 32'd0);
        @(posedge clk);
        #1;
        issue("div_after_kill", 3'd4, 32'd100, 32'd7, 32'd14, 34);
        issue("rem_repeat", 3'd6, 32'd100, 32'd7, 32'd2, 34);
        pulse_reset();
        issue("rem_after_rst", 3'd6, 32'd100, 32'd7, 32'd2, 34);
        bus.ex_funct3 = 3'd4;
        bus.ex_rs1_data = 32'd50;
        bus.ex_rs2_data = 32'd5;
        bus.ex_muldiv = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pulse_reset();
        issue("div_after_midop_rst", 3'd4, 32'd50, 32'd5, 32'd10, 34);
        issue("b2b_mul", 3'd0, 32'd6, 32'd7, 32'd42, 2);
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
